// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard unit for a five-stage in-order core. It forwards operands
// into Execute from Memory and Writeback, stalls Fetch/Decode when a load's
// result is needed by the next instruction, and flushes wrong-path work when
// a branch or jump is taken in Execute. A small FSM reports the hazard
// condition the pipeline is currently recovering from, and holds the pipeline
// in a flushed BOOT condition for two edges after reset.
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous, active-low reset
//   Rs1D, Rs2D            source registers of the instruction in Decode
//   Rs1E, Rs2E            source registers of the instruction in Execute
//   RdE, RdM, RdW         destination registers in Execute/Memory/Writeback
//   ResultSrcE            result select in Execute (2'b01 = load)
//   RegWriteM, RegWriteW  register-write enables in Memory/Writeback
//   PCSrcE                branch/jump taken in Execute
//   StallF, StallD        hold PC / Decode pipeline register
//   FlushD, FlushE        synchronous clear of Decode / Execute register
//   ForwardAE, ForwardBE  operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//   hz_state              FSM state: 00 BOOT, 01 RUN, 10 STALL, 11 REDIRECT
//
// Optional (macro HAZARD_PERF_COUNTERS_EN):
//   perf_clear            zero all counters on the next edge (wins over count)
//   cyc_cnt               cycles spent outside BOOT
//   stall_cnt             cycles outside BOOT with StallF asserted
//   flush_cnt             cycles outside BOOT with PCSrcE asserted
// All counters saturate at 32'hFFFFFFFF.
// -----------------------------------------------------------------------------
module hazard_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic [1:0]  ResultSrcE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        PCSrcE,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic [1:0]  hz_state
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   input  logic        perf_clear,
   output logic [31:0] cyc_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      BOOT     = 2'b00,
      RUN      = 2'b01,
      STALL    = 2'b10,
      REDIRECT = 2'b11
   } hzState_t;

   hzState_t state, nextState;
   logic     bootCnt;   // 0 on the first BOOT edge after reset, 1 on the second
   logic     lwStall;

   // Forwarding select for one Execute source operand. Memory is the younger
   // producer, so it takes priority over Writeback; x0 is never forwarded.
   function automatic logic [1:0] fwdSel(
      input logic [4:0] rs,
      input logic [4:0] rdM,
      input logic       wrM,
      input logic [4:0] rdW,
      input logic       wrW
   );
      if (wrM && (rdM != 5'd0) && (rdM == rs))      return 2'b10;
      else if (wrW && (rdW != 5'd0) && (rdW == rs)) return 2'b01;
      else                                          return 2'b00;
   endfunction

   // A load in Execute whose destination is read by the instruction in Decode.
   assign lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

   assign hz_state = state;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create simulation order races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= BOOT;
         bootCnt <= 1'b0;
      end else begin
         state   <= nextState;
         bootCnt <= (state == BOOT) ? ~bootCnt : 1'b0;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      nextState = state;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;

      if (state == BOOT) begin
         // Hold PC and keep both downstream registers empty until boot ends.
         StallF = 1'b1;
         FlushD = 1'b1;
         FlushE = 1'b1;
         if (bootCnt) nextState = RUN;
      end else begin
         ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         // A taken branch discards the stalled instruction anyway, so it
         // overrides the load-use stall.
         StallF    = lwStall & ~PCSrcE;
         StallD    = lwStall & ~PCSrcE;
         FlushD    = PCSrcE;
         FlushE    = PCSrcE | lwStall;
         if (PCSrcE)       nextState = REDIRECT;
         else if (lwStall) nextState = STALL;
         else              nextState = RUN;
      end
   end

`ifdef HAZARD_PERF_COUNTERS_EN
   function automatic logic [31:0] satInc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (perf_clear) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state != BOOT) begin
         cyc_cnt   <= satInc(cyc_cnt, 1'b1);
         stall_cnt <= satInc(stall_cnt, StallF);
         flush_cnt <= satInc(flush_cnt, PCSrcE);
      end
   end
`endif

endmodule
